// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter shared definitions
// owner encoding and default bus widths, also used by DataMem
package dmem_arbiter_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  typedef logic [1:0] owner_t;

  localparam owner_t IDLE = 2'd0;
  localparam owner_t OWN0 = 2'd1;
  localparam owner_t OWN1 = 2'd2;

endpackage

// File: rtl/arb_read_reg.sv
// dmem_arbiter per-port read return register
// captures combinational memory data on a granted read beat
module arb_read_reg #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cap,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] rdata,
  output logic          rvalid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= cap;
      if (cap) rdata <= d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port DataMem arbiter
// core priority, locked loader bursts, bounded starvation
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = 4,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int LW = $clog2(MAX_LOCK + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);
  localparam logic [LW-1:0] LOCK_MAX = LW'(MAX_LOCK);

  owner_t        owner;
  logic [WW-1:0] wait_cnt;
  logic [LW-1:0] lock_cnt;
  logic          keep1;
  logic          starve1;
  logic          win0;
  logic          win1;

  // rule ordering folded into two mutually exclusive terms
  always_comb begin
    keep1 = (owner == OWN1) & lock1 & req1
          & (lock_cnt < LOCK_MAX);
    starve1 = req1 & (wait_cnt == WAIT_MAX);
    win1 = keep1 | starve1 | (req1 & ~req0);
    win0 = req0 & ~keep1 & ~starve1;
  end

  assign gnt0 = rst & win0;
  assign gnt1 = rst & win1;

  assign mem_addr  = gnt1 ? addr1 : addr0;
  assign mem_wdata = gnt1 ? wdata1 : wdata0;
  assign mem_we    = (gnt0 & we0) | (gnt1 & we1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner    <= IDLE;
      wait_cnt <= '0;
      lock_cnt <= '0;
    end else begin
      unique case (1'b1)
        gnt0:    owner <= OWN0;
        gnt1:    owner <= OWN1;
        default: owner <= IDLE;
      endcase
      if (!req1 || gnt1) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      // saturates so rule 1 stays off until the burst breaks
      if (gnt1 && lock1) begin
        if (lock_cnt != LOCK_MAX) lock_cnt <= lock_cnt + 1'b1;
      end else begin
        lock_cnt <= '0;
      end
    end
  end

  arb_read_reg #(.DW(DW)) u_rd0 (
    .clk    (clk),
    .rst    (rst),
    .cap    (gnt0 & ~we0),
    .d      (mem_rdata),
    .rdata  (rdata0),
    .rvalid (rvalid0)
  );

  arb_read_reg #(.DW(DW)) u_rd1 (
    .clk    (clk),
    .rst    (rst),
    .cap    (gnt1 & ~we1),
    .d      (mem_rdata),
    .rdata  (rdata1),
    .rvalid (rvalid1)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scenario tasks against a rule-level
// grant/memory reference model with random traffic
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int MAX_WAIT = 4;
  localparam int MAX_LOCK = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        gnt0, rvalid0;
  logic [31:0] rdata0;
  logic        req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
  logic [31:0] addr1 = '0, wdata1 = '0;
  logic        gnt1, rvalid1;
  logic [31:0] rdata1;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rdata0(rdata0), .rvalid0(rvalid0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .lock1(lock1), .gnt1(gnt1), .rdata1(rdata1), .rvalid1(rvalid1),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // DataMem stand-in: combinational read, clocked write
  logic [31:0] dmem [0:255];
  always_comb mem_rdata = dmem[mem_addr[9:2]];
  always @(posedge clk) if (mem_we) dmem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        lock;
    int          start;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   trace[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] ref_mem [0:255];
  int          m_last = 0, m_denied = 0, m_locked = 0;
  int          e_win;
  logic        e_we, e_rv0, e_rv1;
  logic [31:0] e_addr, e_rd0 = '0, e_rd1 = '0;
  logic        o_g0, o_g1, o_we, o_rv0, o_rv1;
  logic [31:0] o_addr, o_rd0, o_rd1;

  function automatic txn_t mk(logic we, logic [31:0] a,
                              logic [31:0] d, logic lk, int st);
    txn_t t;
    t.we = we; t.addr = a; t.data = d; t.lock = lk; t.start = st;
    return t;
  endfunction

  task automatic model_reset();
    m_last = 0; m_denied = 0; m_locked = 0;
    e_rd0 = '0; e_rd1 = '0;
  endtask

  task automatic cycle();
    logic r0, r1;
    txn_t t0, t1;
    int   w;
    r0 = q0.size() > 0 && q0[0].start <= cyc;
    r1 = q1.size() > 0 && q1[0].start <= cyc;
    t0 = r0 ? q0[0] : mk(1'b0, '0, '0, 1'b0, 0);
    t1 = r1 ? q1[0] : mk(1'b0, '0, '0, 1'b0, 0);
    req0 = r0; we0 = t0.we; addr0 = t0.addr; wdata0 = t0.data;
    req1 = r1; we1 = t1.we; addr1 = t1.addr; wdata1 = t1.data;
    lock1 = t1.lock;
    if (m_last == 2 && lock1 && req1 && m_locked < MAX_LOCK) w = 1;
    else if (req1 && m_denied >= MAX_WAIT) w = 1;
    else if (req0) w = 0;
    else if (req1) w = 1;
    else w = -1;
    e_win  = w;
    e_we   = (w == 0) ? we0 : (w == 1) ? we1 : 1'b0;
    e_addr = (w == 1) ? addr1 : addr0;
    #1;
    o_g0 = gnt0; o_g1 = gnt1; o_we = mem_we; o_addr = mem_addr;
    trace.push_back(o_g1 ? 1 : o_g0 ? 0 : -1);
    @(posedge clk); #1;
    e_rv0 = (w == 0) && !we0;
    e_rv1 = (w == 1) && !we1;
    if (e_rv0) e_rd0 = ref_mem[addr0[9:2]];
    if (e_rv1) e_rd1 = ref_mem[addr1[9:2]];
    if (w == 0 && we0) ref_mem[addr0[9:2]] = wdata0;
    if (w == 1 && we1) ref_mem[addr1[9:2]] = wdata1;
    m_denied = (req1 && w != 1) ?
      ((m_denied + 1 > MAX_WAIT) ? MAX_WAIT : m_denied + 1) : 0;
    m_locked = (w == 1 && lock1) ?
      ((m_locked + 1 > MAX_LOCK) ? MAX_LOCK : m_locked + 1) : 0;
    m_last = (w < 0) ? 0 : w + 1;
    if (r0 && o_g0) void'(q0.pop_front());
    if (r1 && o_g1) void'(q1.pop_front());
    o_rv0 = rvalid0; o_rv1 = rvalid1; o_rd0 = rdata0; o_rd1 = rdata1;
    cyc++;
  endtask

  task automatic test_reset();
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({gnt0, gnt1, mem_we, rvalid0, rvalid1} !== 5'b0 ||
        {rdata0, rdata1} !== 64'h0) begin
      bad++;
      $display("FAIL reset_state got g0=%b g1=%b we=%b rv=%b%b rd0=%h rd1=%h want all 0",
               gnt0, gnt1, mem_we, rvalid0, rvalid1, rdata0, rdata1);
    end
    total++;
    if (dut.owner !== IDLE) begin
      bad++;
      $display("FAIL reset_owner got %0d want %0d", dut.owner, IDLE);
    end
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    rst = 1'b1;
    model_reset();
  endtask

  task automatic test_core_read();
    int n = 0;
    q1.push_back(mk(1'b1, 32'h20, 32'hDEADBEEF, 1'b0, cyc));
    q0.push_back(mk(1'b0, 32'h20, '0, 1'b0, cyc + 1));
    while ((q0.size() > 0 || q1.size() > 0) && n < 50) begin
      cycle(); n++;
      total++;
      if ({o_g0, o_g1, o_we, o_addr} !==
          {e_win == 0, e_win == 1, e_we, e_addr}) begin
        bad++;
        $display("FAIL core_read_grant cyc=%0d got %b%b%b %h want %b%b%b %h",
                 cyc, o_g0, o_g1, o_we, o_addr,
                 e_win == 0, e_win == 1, e_we, e_addr);
      end
    end
    total++;
    if (q0.size() > 0 || q1.size() > 0) begin
      bad++; $display("FAIL core_read_timeout got pending want none");
      q0.delete(); q1.delete();
    end
    total++;
    if (o_rv0 !== 1'b1 || o_rd0 !== 32'hDEADBEEF || o_we !== 1'b0) begin
      bad++;
      $display("FAIL core_read_data got rv=%b rd=%h we=%b want 1 deadbeef 0",
               o_rv0, o_rd0, o_we);
    end
  endtask

  task automatic test_contention();
    int n = 0;
    int ts = trace.size();
    for (int i = 0; i < 10; i++) begin
      q0.push_back(mk(1'b0, 32'h20, '0, 1'b0, cyc));
      q1.push_back(mk(1'b0, 32'h20, '0, 1'b0, cyc));
    end
    while ((q0.size() > 0 || q1.size() > 0) && n < 100) begin
      cycle(); n++;
      total++;
      if ({o_rv0, o_rv1, o_rd0, o_rd1} !== {e_rv0, e_rv1, e_rd0, e_rd1}) begin
        bad++;
        $display("FAIL contention_read cyc=%0d got %b%b %h %h want %b%b %h %h",
                 cyc, o_rv0, o_rv1, o_rd0, o_rd1, e_rv0, e_rv1, e_rd0, e_rd1);
      end
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (trace[ts + i] !== ((i % 5 == 4) ? 1 : 0)) begin
        bad++;
        $display("FAIL contention_pattern beat=%0d got port %0d want port %0d",
                 i, trace[ts + i], (i % 5 == 4) ? 1 : 0);
      end
    end
  endtask

  task automatic test_locked_burst();
    int n = 0;
    int ts = trace.size();
    logic [31:0] d [8];
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom;
      q1.push_back(mk(1'b1, 32'h100 + 32'(4 * i), d[i], 1'b1, cyc));
    end
    while (q1.size() > 0 && n < 50) begin
      cycle(); n++;
      total++;
      if (o_g1 !== 1'b1 || o_we !== 1'b1) begin
        bad++;
        $display("FAIL burst_beat cyc=%0d got g1=%b we=%b want 1 1",
                 cyc, o_g1, o_we);
      end
    end
    total++;
    if (trace.size() - ts !== 8) begin
      bad++;
      $display("FAIL burst_len got %0d want 8", trace.size() - ts);
      q1.delete();
    end
    for (int i = 0; i < 8; i++) begin
      total++;
      if (dmem[64 + i] !== d[i]) begin
        bad++;
        $display("FAIL burst_mem idx=%0d got %h want %h", i, dmem[64 + i], d[i]);
      end
    end
  endtask

  task automatic test_lock_cap();
    int n = 0;
    int ts = trace.size() + 1;
    for (int i = 0; i < 12; i++)
      q1.push_back(mk(1'b1, 32'h180 + 32'(4 * i), $urandom, 1'b1, cyc + 1));
    q0.push_back(mk(1'b0, 32'h100, '0, 1'b0, cyc + 3));
    while ((q0.size() > 0 || q1.size() > 0) && n < 60) begin
      cycle(); n++;
      total++;
      if ({o_g0, o_g1, o_rv0, o_rd0} !== {e_win == 0, e_win == 1, e_rv0, e_rd0}) begin
        bad++;
        $display("FAIL lock_cap_model cyc=%0d got %b%b %b %h want %b%b %b %h",
                 cyc, o_g0, o_g1, o_rv0, o_rd0,
                 e_win == 0, e_win == 1, e_rv0, e_rd0);
      end
    end
    for (int i = 0; i < 13; i++) begin
      total++;
      if (trace[ts + i] !== ((i == 8) ? 0 : 1)) begin
        bad++;
        $display("FAIL lock_cap_pattern beat=%0d got port %0d want port %0d",
                 i, trace[ts + i], (i == 8) ? 0 : 1);
      end
    end
  endtask

  task automatic test_wr_rd_order();
    int n = 0;
    q1.push_back(mk(1'b1, 32'h40, 32'h55, 1'b0, cyc));
    q0.push_back(mk(1'b0, 32'h40, '0, 1'b0, cyc + 1));
    while ((q0.size() > 0 || q1.size() > 0) && n < 20) begin
      cycle(); n++;
    end
    total++;
    if (o_rv0 !== 1'b1 || o_rd0 !== 32'h55) begin
      bad++;
      $display("FAIL wr_rd_order got rv=%b rd=%h want 1 00000055", o_rv0, o_rd0);
    end
  endtask

  task automatic test_random();
    int n = 0;
    int s0 = cyc, s1 = cyc;
    for (int i = 0; i < 16; i++)
      q1.push_back(mk(1'b1, 32'h200 + 32'(4 * i), $urandom, 1'b0, cyc));
    for (int i = 0; i < 80; i++) begin
      s0 += $urandom_range(0, 2);
      s1 += $urandom_range(0, 2);
      q0.push_back(mk(1'($urandom_range(0, 1)),
                      32'h200 + 32'(4 * $urandom_range(0, 15)),
                      $urandom, 1'b0, s0 + 16));
      q1.push_back(mk(1'($urandom_range(0, 1)),
                      32'h200 + 32'(4 * $urandom_range(0, 15)),
                      $urandom, 1'($urandom_range(0, 2) != 0), s1 + 16));
    end
    while ((q0.size() > 0 || q1.size() > 0) && n < 2000) begin
      cycle(); n++;
      total++;
      if ({o_g0, o_g1, o_we, o_addr} !==
          {e_win == 0, e_win == 1, e_we, e_addr}) begin
        bad++;
        $display("FAIL random_grant cyc=%0d got %b%b%b %h want %b%b%b %h",
                 cyc, o_g0, o_g1, o_we, o_addr,
                 e_win == 0, e_win == 1, e_we, e_addr);
      end
      total++;
      if ({o_rv0, o_rv1, o_rd0, o_rd1} !== {e_rv0, e_rv1, e_rd0, e_rd1}) begin
        bad++;
        $display("FAIL random_read cyc=%0d got %b%b %h %h want %b%b %h %h",
                 cyc, o_rv0, o_rv1, o_rd0, o_rd1, e_rv0, e_rv1, e_rd0, e_rd1);
      end
    end
    total++;
    if (q0.size() > 0 || q1.size() > 0) begin
      bad++; $display("FAIL random_timeout got pending want none");
      q0.delete(); q1.delete();
    end
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
    req1 = 1'b0; lock1 = 1'b0;
    #1;
    total++;
    if (gnt0 !== 1'b1) begin
      bad++; $display("FAIL reset_mid_pre got gnt0=%b want 1", gnt0);
    end
    rst = 1'b0;
    #1;
    total++;
    if ({gnt0, gnt1, mem_we, rvalid0, rvalid1} !== 5'b0 ||
        {rdata0, rdata1} !== 64'h0) begin
      bad++;
      $display("FAIL reset_mid_async got g0=%b g1=%b we=%b rv=%b%b rd0=%h want 0",
               gnt0, gnt1, mem_we, rvalid0, rvalid1, rdata0);
    end
    @(posedge clk); #1;
    total++;
    if (rvalid0 !== 1'b0 || dut.owner !== IDLE) begin
      bad++;
      $display("FAIL reset_mid_edge got rv0=%b owner=%0d want 0 %0d",
               rvalid0, dut.owner, IDLE);
    end
    req0 = 1'b0;
    rst = 1'b1;
    model_reset();
    q0.push_back(mk(1'b0, 32'h40, '0, 1'b0, cyc));
    cycle(); cycle();
    total++;
    if (q0.size() > 0 || o_rv0 !== 1'b0 || o_rd0 !== 32'h55) begin
      bad++;
      $display("FAIL reset_mid_after got rv=%b rd=%h want 0 00000055",
               o_rv0, o_rd0);
      q0.delete();
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_contention();
    test_locked_burst();
    test_lock_cap();
    test_wr_rd_order();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single-port DataMem between two requesters: port 0 is the riscv core load/store path and port 1 is a loader/DMA master used for program and data preload. The block arbitrates per cycle with core priority, supports locked bursts on port 1, and bounds starvation on both sides. It sits between riscv/loader and DataMem in the SoC top; the core stalls while its grant is low.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_WAIT, 4, consecutive denied cycles after which port 1 wins the next beat
MAX_LOCK, 8, maximum consecutive locked port-1 beats before a forced release

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-low reset
req0  in  1  core access request
we0  in  1  core write enable (1 = store)
addr0  in  AW  core address
wdata0  in  DW  core store data
gnt0  out  1  core beat accepted this cycle (combinational)
rdata0  out  DW  core load data, registered
rvalid0  out  1  rdata0 valid (one cycle pulse)
req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1  same as port 0, for the loader
lock1  in  1  loader requests to keep ownership for the next beat
mem_we  out  1  to DataMem we
mem_addr  out  AW  to DataMem addr
mem_wdata  out  DW  to DataMem data_i
mem_rdata  in  DW  from DataMem data_o (combinational read)

Behaviour:
- State: owner in {IDLE, OWN0, OWN1}; wait_cnt (0..MAX_WAIT, saturating); lock_cnt (0..MAX_LOCK).
- Grant priority, evaluated combinationally each cycle, first match wins:
  1. owner==OWN1 & lock1 & req1 & lock_cnt<MAX_LOCK -> gnt1.
  2. req1 & wait_cnt==MAX_WAIT -> gnt1.
  3. req0 -> gnt0.
  4. req1 -> gnt1.
  5. otherwise no grant.
- gnt0 and gnt1 are never high together; a grant is never given without its req.
- A beat transfers in any cycle where reqX & gntX. The requester holds req/we/addr/wdata stable until it sees gnt.
- Memory drive: mem_addr/mem_wdata come from the granted port, or from port 0 when nothing is granted. mem_we = (gnt0 & we0) | (gnt1 & we1), and is 0 with no grant.
- Reads: for a granted beat with weX=0, rdataX <= mem_rdata and rvalidX <= 1 at the next edge. rvalidX is 0 in every other cycle; rdataX holds its last value. Writes never raise rvalid. Read latency is 1 cycle after the grant.
- Owner update at each edge: OWN0 if gnt0, OWN1 if gnt1, IDLE otherwise.
- wait_cnt: increments (saturating) when req1 & !gnt1; clears to 0 on gnt1 or when req1 is low.
- lock_cnt: increments on a gnt1 beat taken via rule 1 or with lock1 high; clears on any non-port-1 cycle or when lock1 is low.
  - Reaching lock_cnt==MAX_LOCK disables rule 1, so port 0 wins the next beat if requesting. lock_cnt clears after that beat.
- lock1 with req1 low releases ownership immediately; lock1 while owner!=OWN1 has no effect.
- Simultaneous req0 & req1 from IDLE: port 0 wins (rule 3), unless starvation rule 2 applies.
- Reset (rst low, asynchronous): owner=IDLE, wait_cnt=0, lock_cnt=0, rvalid0=rvalid1=0, rdata0=rdata1=0. Grants are forced to 0 while rst is low. A beat in flight when reset asserts is discarded, with no rvalid.

Decomposition:
- Shared package holds: owner state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the default AW/DW values, shared with DataMem.
- One natural sub-module: arb_read_reg (per-port registered rdata/rvalid capture), instantiated twice.
- Grant logic and counters stay in the top.

Test Plan:
- Reset mid-traffic: req0=1 read of 0x10, then rst low for 1 cycle -> rvalid0=0, gnt0=0 during reset, owner=IDLE, rdata0=0.
- Core-only read: preload mem[0x20]=0xDEADBEEF, req0 read 0x20 -> gnt0 same cycle, rvalid0=1 with rdata0=0xDEADBEEF next cycle, mem_we=0 throughout.
- Contention: req0 and req1 held high continuously with MAX_WAIT=4 -> gnt0 for 4 cycles, gnt1 on the 5th, then the pattern repeats.
- Locked burst: loader writes 0x100..0x11C (8 beats, lock1=1) while req0 is idle -> 8 consecutive gnt1 beats, mem_we=1, and memory holds the data.
- Lock cap: lock1=1 and req1 held for 12 beats with req0 asserted at beat 3 -> exactly MAX_LOCK=8 locked gnt1 beats, then one gnt0, then port 1 resumes.
- Write/read ordering: loader writes 0x55 to 0x40, core reads 0x40 in the next cycle -> rdata0=0x55.
